shift194_seq: RTL
=================

Name: shift194_seq

Overview:
Sequencer that drives a 4-bit universal shift register (74x194-style) directly upstream of it. It accepts a job with a valid/ready handshake: a parallel word, a direction and a fill bit. It then issues one parallel load followed by SHIFT_CNT shift cycles on the register's S1/S0/Din/Dsl/Dsr pins, and presents each outgoing serial bit with a valid strobe. It pulses done on completion and is used for parallel-to-serial framing around the register.

Parameters:
SHIFT_CNT, 4, number of shift cycles per job (legal 0..15)
CNT_W, 4, shift counter width (must hold SHIFT_CNT)

Ports:
CP  input  1  clock, rising edge
CR  input  1  synchronous clear, active-high
start_valid  input  1  job request
start_ready  output  1  job can be accepted (high only in IDLE)
word_in  input  4  parallel word to load
dir  input  1  0: shift toward Q[0], Dsr enters Q[3]; 1: shift toward Q[3], Dsl enters Q[0]
fill  input  1  serial fill bit
start_rot  input  1  rotate request (used only with ROTATE_EN)
abort  input  1  cancel the job in progress
Q_fb  input  4  feedback of the register's Q
S1  output  1  register mode select high bit
S0  output  1  register mode select low bit
Din  output  4  register parallel data
Dsl  output  1  serial input entering Q[0]
Dsr  output  1  serial input entering Q[3]
ser_out  output  1  bit leaving the register this cycle
ser_valid  output  1  ser_out is valid
done  output  1  one-cycle completion pulse

Behaviour:
- One clock, CP. CR is synchronous and active-high. CR has priority over all other inputs.
- CR state: IDLE. Counter and latched word/dir/fill/rot are 0. Outputs: S1=S0=0, Din=0, Dsl=Dsr=0, ser_valid=0, done=0, start_ready=1.
- FSM is Moore. All outputs decode from registered state only, so the register samples them on the same CP edge.
- IDLE: S=00 (hold), start_ready=1. When start_valid=1, latch word_in/dir/fill/start_rot and go to LOAD. Inputs are sampled only on the accept edge.
- LOAD (1 cycle): S=11, Din=latched word. Next state is SHIFT, or DONE if SHIFT_CNT=0. Counter clears to 0.
- SHIFT (SHIFT_CNT cycles):
  - dir=0: S=01, Dsr=serial-in, ser_out=Q_fb[0].
  - dir=1: S=10, Dsl=serial-in, ser_out=Q_fb[3].
  - The unused serial pin is 0. ser_valid=1.
  - Counter increments each cycle. Go to DONE when counter==SHIFT_CNT-1.
- DONE (1 cycle): S=00, done=1. Next state is IDLE.
- Din=0 outside LOAD.
- abort=1 in LOAD or SHIFT: next state IDLE, S=00, no done pulse, register contents left as-is. abort is ignored in IDLE and DONE.
- start_valid outside IDLE is ignored; there is no buffering.
- Job timeline for accept at cycle t: LOAD at t+1, SHIFT at t+2..t+1+N, DONE at t+2+N, next accept no earlier than t+3+N.
- CR mid-job: the job is discarded next cycle and all outputs return to reset values.

Optional Feature:
ROTATE_EN
- Defined: when the latched rot=1, serial-in equals the outgoing bit (dir=0: Dsr=Q_fb[0]; dir=1: Dsl=Q_fb[3]). With SHIFT_CNT=4 the word is restored after the job.
- Undefined: start_rot is ignored, no rot flop is built, and serial-in is always the latched fill.

Decomposition:
- Package shift194_pkg holds:
  - state enum: IDLE, LOAD, SHIFT, DONE
  - mode constants: MODE_HOLD=2'b00, MODE_TO_LSB=2'b01, MODE_TO_MSB=2'b10, MODE_LOAD=2'b11
- No sub-module is needed; this is a single module.
- The bench instantiates the existing 4-bit register with Q looped back to Q_fb and the register's active-low clear tied high.

Test Plan:
- word=1011, dir=0, fill=0, N=4 -> S sequence 11,01,01,01,01,00; ser_out 1,1,0,1; final Q=0000; done high exactly once at t+6.
- word=1011, dir=1, fill=1 -> ser_out 1,0,1,1; final Q=1111.
- ROTATE_EN, word=1011, start_rot=1, dir=0 -> ser_out 1,1,0,1; final Q=1011. Without the macro, same stimulus -> Q=0000.
- word=1011, dir=0, fill=0, abort after the 2nd SHIFT cycle -> Q=0010, done never pulses, start_ready=1 next cycle.
- start_valid held high -> accepts at t and t+7 only, start_ready low for 6 cycles; CR asserted in SHIFT -> next cycle S=00, ser_valid=0, start_ready=1.
- SHIFT_CNT=0 -> LOAD then DONE, ser_valid never asserts, Q=word_in.

Source files
------------

// File: rtl/shift194_pkg.sv
// Shared state encoding and register mode-select constants for the 74x194 sequencer.
package shift194_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_TO_LSB = 2'b01;
  localparam logic [1:0] MODE_TO_MSB = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

endpackage

// File: rtl/shift194_seq.sv
// Sequencer for a 4-bit 74x194-style universal shift register: load, then SHIFT_CNT shifts.
// Optional macro ROTATE_EN makes the serial input recirculate the outgoing bit.
module shift194_seq
  import shift194_pkg::*;
#(
  parameter int SHIFT_CNT = 4,
  parameter int CNT_W     = 4
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [3:0] word_in,
  input  logic       dir,
  input  logic       fill,
  input  logic       start_rot,
  input  logic       abort,
  input  logic [3:0] Q_fb,
  output logic       S1,
  output logic       S0,
  output logic [3:0] Din,
  output logic       Dsl,
  output logic       Dsr,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       done
);

  localparam logic [CNT_W-1:0] LAST_CNT =
    (SHIFT_CNT == 0) ? '0 : CNT_W'(SHIFT_CNT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       word_q, word_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic             serial_in;
  logic             out_bit;
  logic [1:0]       mode;

`ifdef ROTATE_EN
  logic rot_q, rot_d;
  logic unused_fb;
  assign unused_fb = ^Q_fb[2:1];
`else
  logic unused_in;
  assign unused_in = start_rot ^ (^Q_fb[2:1]);
`endif

  always_ff @(posedge CP) begin
    if (CR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
`ifdef ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
`ifdef ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  // Job inputs are captured only on the accept edge; abort only matters mid-job.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
`ifdef ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          word_d  = word_in;
          dir_d   = dir;
          fill_d  = fill;
`ifdef ROTATE_EN
          rot_d   = start_rot;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d = '0;
        if (abort)               state_d = IDLE;
        else if (SHIFT_CNT == 0) state_d = DONE;
        else                     state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (abort)                   state_d = IDLE;
        else if (cnt_q == LAST_CNT)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_bit = dir_q ? Q_fb[3] : Q_fb[0];
`ifdef ROTATE_EN
    serial_in = rot_q ? out_bit : fill_q;
`else
    serial_in = fill_q;
`endif
  end

  // Moore decode: the register samples these on the same edge that advances state.
  always_comb begin
    mode        = MODE_HOLD;
    Din         = '0;
    Dsl         = 1'b0;
    Dsr         = 1'b0;
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    done        = 1'b0;
    start_ready = 1'b0;
    case (state_q)
      IDLE: start_ready = 1'b1;
      LOAD: begin
        mode = MODE_LOAD;
        Din  = word_q;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = out_bit;
        if (dir_q) begin
          mode = MODE_TO_MSB;
          Dsl  = serial_in;
        end else begin
          mode = MODE_TO_LSB;
          Dsr  = serial_in;
        end
      end
      DONE:    done = 1'b1;
      default: mode = MODE_HOLD;
    endcase
    S1 = mode[1];
    S0 = mode[0];
  end

endmodule
